// File: rtl/dc_ascii_hex_word.sv
// dc_ascii_hex_word
//   Streaming ASCII hex-string parser. Takes one character per cycle over a
//   valid/ready handshake, decodes hex digits case-insensitively and packs
//   them MSB-first into a WIDTH-bit word. A word is emitted on a separator
//   (space, tab, LF, CR, optionally ',') or as soon as NUM_DIGITS digits
//   have been collected. Any other character discards the current token
//   and pulses ERR.
//
//   Parameters:
//     WIDTH     - output word width, multiple of 4 and >= 8
//     SEP_COMMA - 1: ',' is a separator, 0: ',' is invalid
//
//   Optional feature macro: DC_ASCII_HEX_PREFIX_0X_EN
//     When defined, a leading "0x"/"0X" on a token is accepted and dropped.
//
//   Ports:
//     CLK, RST_N          - clock (rising edge), async active-low reset
//     IN_ASCII/IN_VLD/IN_RDY - character input handshake
//     OUT_DATA/OUT_CNT    - parsed word (right-justified) and digit count
//     OUT_VLD/OUT_RDY     - word output handshake
//     ERR                 - one-cycle pulse on a discarded token
module dc_ascii_hex_word #(
    parameter int WIDTH      = 32,
    parameter int SEP_COMMA  = 1,
    localparam int NUM_DIGITS = WIDTH / 4,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       IN_ASCII,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [CNT_W-1:0] OUT_CNT,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    output logic             ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic             err_q, err_d;
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
    logic             prefix_seen_q, prefix_seen_d;
    logic             is_x;
`endif

    logic             accept;
    logic             is_digit;
    logic             is_sep;
    logic [3:0]       nibble;
    logic [CNT_W-1:0] cnt_inc;

    assign accept = IN_VLD && !out_vld_q;

    // Character classification
    always_comb begin
        is_digit = 1'b0;
        nibble   = '0;
        if (IN_ASCII >= 8'h30 && IN_ASCII <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = IN_ASCII[3:0];
        end else if ((IN_ASCII >= 8'h41 && IN_ASCII <= 8'h46) ||
                     (IN_ASCII >= 8'h61 && IN_ASCII <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 0xA..0xF
            is_digit = 1'b1;
            nibble   = IN_ASCII[3:0] + 4'd9;
        end
        is_sep = (IN_ASCII == 8'h20) || (IN_ASCII == 8'h09) ||
                 (IN_ASCII == 8'h0A) || (IN_ASCII == 8'h0D) ||
                 ((SEP_COMMA != 0) && (IN_ASCII == 8'h2C));
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
        is_x = (IN_ASCII == 8'h78) || (IN_ASCII == 8'h58);
`endif
    end

    // Next-state logic
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        out_vld_d  = out_vld_q;
        err_d      = 1'b0;
        cnt_inc    = cnt_q + CNT_W'(1);
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
        prefix_seen_d = prefix_seen_q;
`endif

        if (state_q == S_HOLD && OUT_RDY) begin
            out_vld_d = 1'b0;
            state_d   = S_IDLE;
        end

        // accept implies !out_vld_q, so this never overlaps the HOLD exit
        if (accept) begin
            if (is_digit) begin
                if (cnt_inc == CNT_W'(NUM_DIGITS)) begin
                    out_data_d = {acc_q[WIDTH-5:0], nibble};
                    out_cnt_d  = CNT_W'(NUM_DIGITS);
                    out_vld_d  = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_HOLD;
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
                    prefix_seen_d = 1'b0;
`endif
                end else begin
                    acc_d   = {acc_q[WIDTH-5:0], nibble};
                    cnt_d   = cnt_inc;
                    state_d = S_ACCUM;
                end
            end else if (is_sep) begin
                if (cnt_q != '0) begin
                    out_data_d = acc_q;
                    out_cnt_d  = cnt_q;
                    out_vld_d  = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_HOLD;
                end
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
                // a separator ends the token, including a bare "0x"
                prefix_seen_d = 1'b0;
`endif
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
            end else if (is_x && cnt_q == CNT_W'(1) && acc_q == '0 && !prefix_seen_q) begin
                acc_d         = '0;
                cnt_d         = '0;
                state_d       = S_IDLE;
                prefix_seen_d = 1'b1;
`endif
            end else begin
                err_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
                prefix_seen_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
            prefix_seen_q <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
            err_q      <= err_d;
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
            prefix_seen_q <= prefix_seen_d;
`endif
        end
    end

    assign IN_RDY   = !out_vld_q;
    assign OUT_DATA = out_data_q;
    assign OUT_CNT  = out_cnt_q;
    assign OUT_VLD  = out_vld_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_dc_ascii_hex_word.sv
module tb_dc_ascii_hex_word;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] IN_ASCII = 8'h00;
    logic       IN_VLD = 1'b0;
    logic       OUT_RDY = 1'b1;

    // DUT 0: WIDTH=16, DUT 1: WIDTH=32, DUT 2: WIDTH=32 with SEP_COMMA=0
    logic        r0, r1, r2, v0, v1, v2, e0, e1, e2;
    logic [15:0] d0;
    logic [31:0] d1, d2;
    logic [2:0]  c0;
    logic [3:0]  c1, c2;

    dc_ascii_hex_word #(.WIDTH(16)) u_w16 (
        .CLK(CLK), .RST_N(RST_N), .IN_ASCII(IN_ASCII), .IN_VLD(IN_VLD), .IN_RDY(r0),
        .OUT_DATA(d0), .OUT_CNT(c0), .OUT_VLD(v0), .OUT_RDY(OUT_RDY), .ERR(e0));
    dc_ascii_hex_word #(.WIDTH(32)) u_w32 (
        .CLK(CLK), .RST_N(RST_N), .IN_ASCII(IN_ASCII), .IN_VLD(IN_VLD), .IN_RDY(r1),
        .OUT_DATA(d1), .OUT_CNT(c1), .OUT_VLD(v1), .OUT_RDY(OUT_RDY), .ERR(e1));
    dc_ascii_hex_word #(.WIDTH(32), .SEP_COMMA(0)) u_w32_nc (
        .CLK(CLK), .RST_N(RST_N), .IN_ASCII(IN_ASCII), .IN_VLD(IN_VLD), .IN_RDY(r2),
        .OUT_DATA(d2), .OUT_CNT(c2), .OUT_VLD(v2), .OUT_RDY(OUT_RDY), .ERR(e2));

    always #5 CLK = ~CLK;

    int sel = 0;
    logic        in_rdy, vld, err;
    logic [31:0] data;
    logic [3:0]  cnt;

    always_comb begin
        case (sel)
            0:       begin in_rdy = r0; vld = v0; err = e0; data = {16'h0, d0}; cnt = {1'b0, c0}; end
            1:       begin in_rdy = r1; vld = v1; err = e1; data = d1; cnt = c1; end
            default: begin in_rdy = r2; vld = v2; err = e2; data = d2; cnt = c2; end
        endcase
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] d; logic [3:0] c; } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        IN_VLD = 1'b0;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        while (!in_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!in_rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_rdy=%0b after %0d cycles, required 1", in_rdy, n);
        end
        IN_ASCII = c;
        IN_VLD = 1'b1;
        tick();
        IN_VLD = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            RST_N = 1'b0;
            #1;
            checks++;
            if ({vld, err, data, cnt} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: vld=%0b err=%0b data=%h cnt=%0d, required all 0", s, vld, err, data, cnt);
            end
        end
        tick();
        RST_N = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (in_rdy !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_rdy dut%0d: got %0b, required 1", s, in_rdy);
            end
        end
    endtask

    task automatic test_full_word();
        sel = 0;
        apply_reset();
        OUT_RDY = 1'b1;
        send_str("1A2");
        checks++;
        if (vld !== 1'b0) begin failures++; $display("FAIL full_early_vld: got %0b, required 0", vld); end
        sb.push_back('{32'h1A2F, 4'd4});
        send_char("f");
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL full_word: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
        send_char(8'h0A);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vld !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL full_sep_ignored: vld=%0b err=%0b, required 0 0", vld, err);
            end
            tick();
        end
    endtask

    task automatic test_separator();
        sel = 0;
        apply_reset();
        send_char("7");
        sb.push_back('{32'h0007, 4'd1});
        send_char(" ");
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL sep_word: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL sep_in_rdy: got %0b, required 0", in_rdy); end
    endtask

    task automatic test_invalid();
        sel = 0;
        apply_reset();
        send_str("12G");
        checks++;
        if (err !== 1'b1 || vld !== 1'b0) begin
            failures++;
            $display("FAIL inv_err: err=%0b vld=%0b, required 1 0", err, vld);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL inv_err_pulse: err=%0b, required 0", err); end
        send_char("3");
        sb.push_back('{32'h0003, 4'd1});
        send_char(8'h0D);
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL inv_recover: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
    endtask

    task automatic test_hold();
        sel = 1;
        apply_reset();
        OUT_RDY = 1'b0;
        send_str("dead");
        sb.push_back('{32'h0000DEAD, 4'd4});
        send_char(",");
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL hold_word: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (vld !== 1'b1 || data !== e.d || cnt !== e.c || in_rdy !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable: vld=%0b data=%h cnt=%0d in_rdy=%0b, required 1 %h %0d 0", vld, data, cnt, in_rdy, e.d, e.c);
            end
        end
        OUT_RDY = 1'b1;
        tick();
        checks++;
        if (vld !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: vld=%0b in_rdy=%0b, required 0 1", vld, in_rdy);
        end
        sel = 2;
        apply_reset();
        send_str("dead,");
        checks++;
        if (err !== 1'b1 || vld !== 1'b0) begin
            failures++;
            $display("FAIL nocomma_err: err=%0b vld=%0b, required 1 0", err, vld);
        end
    endtask

    task automatic test_prefix();
        sel = 0;
        apply_reset();
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
        send_str("0xBEE");
        checks++;
        if (err !== 1'b0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL pfx_no_err: err=%0b vld=%0b, required 0 0", err, vld);
        end
`else
        send_str("0x");
        checks++;
        if (err !== 1'b1 || vld !== 1'b0) begin
            failures++;
            $display("FAIL pfx_x_invalid: err=%0b vld=%0b, required 1 0", err, vld);
        end
        send_str("BEE");
`endif
        sb.push_back('{32'hBEEF, 4'd4});
        send_char("F");
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL pfx_word: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
`ifdef DC_ASCII_HEX_PREFIX_0X_EN
        send_str("0x0X");
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL pfx_second_x: err=%0b, required 1", err); end
        send_str("0x ");
        checks++;
        if (err !== 1'b0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL pfx_bare: err=%0b vld=%0b, required 0 0", err, vld);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        sel = 0;
        apply_reset();
        OUT_RDY = 1'b1;
        send_str("123");
        sb.push_back('{32'h1234, 4'd4});
        send_char("4");
        t1 = cyc;
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL b2b_word1: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
        send_str("567");
        sb.push_back('{32'h5678, 4'd4});
        send_char("8");
        t2 = cyc;
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL b2b_word2: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
        checks++;
        if (t2 - t1 !== 5) begin failures++; $display("FAIL b2b_spacing: got %0d cycles, required 5", t2 - t1); end
    endtask

    task automatic test_mid_reset();
        sel = 0;
        apply_reset();
        send_str("1234");
        tick();
        send_str("AB");
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({vld, err, data, cnt} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: vld=%0b err=%0b data=%h cnt=%0d, required all 0", vld, err, data, cnt);
        end
        tick();
        RST_N = 1'b1;
        tick();
        send_char("C");
        sb.push_back('{32'h000C, 4'd1});
        send_char(" ");
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || data !== e.d || cnt !== e.c) begin
            failures++;
            $display("FAIL midrst_word: vld=%0b data=%h cnt=%0d, required 1 %h %0d", vld, data, cnt, e.d, e.c);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_separator();
        test_invalid();
        test_hold();
        test_prefix();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: %0d entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
